vga_frame_reader: RTL and testbench

// - Downstream display stage. Scans the 640x480 RGB444 frame buffer that the camera capture stage fills.
// - Generates VGA 640x480@60 timing and issues linear read addresses to the frame buffer's read port.
// - Realigns hsync, vsync and blanking with the read data returned by the RAM.
// - Drives the 4-bit-per-channel VGA DAC pins.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_timing_gen.sv | 57 +++++
 rtl/vga_frame_reader.sv | 89 ++++++++
 tb/tb_vga_frame_reader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60 timing constants, frame buffer depth and RGB444 layout
package vga_pkg;

  localparam int VGA_ADDR_W     = 19;
  localparam int VGA_H_ACTIVE   = 640;
  localparam int VGA_H_FP       = 16;
  localparam int VGA_H_SYNC     = 96;
  localparam int VGA_H_BP       = 48;
  localparam int VGA_V_ACTIVE   = 480;
  localparam int VGA_V_FP       = 10;
  localparam int VGA_V_SYNC     = 2;
  localparam int VGA_V_BP       = 33;
  localparam int VGA_RD_LATENCY = 2;
  localparam bit VGA_SYNC_POL   = 1'b0;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int FB_DEPTH    = VGA_H_ACTIVE * VGA_V_ACTIVE;

  // RGB444 word layout, shared with the camera capture stage
  localparam int RGB_W     = 12;
  localparam int RGB_CH_W  = 4;
  localparam int RGB_R_LSB = 8;
  localparam int RGB_G_LSB = 4;
  localparam int RGB_B_LSB = 0;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } vga_ctl_t;

  function automatic logic sync_level(input logic active, input bit pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - h/v scan counters and stage-0 de/hs/vs/frame-start flags
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic     pclk,
  input  logic     rst_n,
  output vga_ctl_t ctl0
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_C  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_C  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Flags are active-high here; polarity is applied only at the output pins
  always_comb begin
    ctl0    = '0;
    ctl0.de = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    ctl0.hs = (h_cnt >= HS_START) && (h_cnt < HS_END);
    ctl0.vs = (v_cnt >= VS_START) && (v_cnt < VS_END);
    ctl0.fs = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - frame buffer scan-out: address counter, latency realignment, VGA pin registers
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int ADDR_W     = VGA_ADDR_W,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int RD_LATENCY = VGA_RD_LATENCY,
  parameter bit SYNC_POL   = VGA_SYNC_POL
) (
  input  logic              pclk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] frame_addr,
  input  logic [RGB_W-1:0]  frame_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  vga_ctl_t         ctl0;
  vga_ctl_t         ctl_pipe [RD_LATENCY];
  vga_ctl_t         ctl_dly;
  logic [RGB_W-1:0] rgb_q;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .pclk  (pclk),
    .rst_n (rst_n),
    .ctl0  (ctl0)
  );

  // Wrapping after the last visible pixel prefetches the next frame's origin during blanking
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_addr <= '0;
    end else if (ctl0.de) begin
      frame_addr <= (frame_addr == ADDR_LAST) ? '0 : frame_addr + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) ctl_pipe[i] <= '0;
    end else begin
      ctl_pipe[0] <= ctl0;
      for (int i = 1; i < RD_LATENCY; i++) ctl_pipe[i] <= ctl_pipe[i-1];
    end
  end

  assign ctl_dly = ctl_pipe[RD_LATENCY-1];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q       <= '0;
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      rgb_q       <= ctl_dly.de ? frame_data : '0;
      vga_hs      <= sync_level(ctl_dly.hs, SYNC_POL);
      vga_vs      <= sync_level(ctl_dly.vs, SYNC_POL);
      frame_start <= ctl_dly.fs;
    end
  end

  assign vga_r = rgb_q[RGB_R_LSB +: RGB_CH_W];
  assign vga_g = rgb_q[RGB_G_LSB +: RGB_CH_W];
  assign vga_b = rgb_q[RGB_B_LSB +: RGB_CH_W];

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - checks four reader instances (latency 2/1/4 full size, latency 3 tiny frame) against a scan model
module tb_vga_frame_reader;

  typedef struct {
    int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp;
    int lat;
  } geo_t;

  logic        pclk;
  logic        rst_n;
  logic        white;
  int          phase;
  int          n;
  int          checks;
  int          errors;

  logic [18:0] fa [4];
  logic [11:0] fd [4];
  logic [3:0]  vr [4];
  logic [3:0]  vg [4];
  logic [3:0]  vb [4];
  logic        hs [4];
  logic        vs [4];
  logic        fs [4];
  logic [11:0] rp [4][4];

  logic [11:0] e_rgb;
  logic        e_hs, e_vs, e_fs;
  int          e_addr;

  initial pclk = 1'b0;
  always #20 pclk = ~pclk;

  vga_frame_reader #(.RD_LATENCY(2)) u_dut (
    .pclk(pclk), .rst_n(rst_n), .frame_addr(fa[0]), .frame_data(fd[0]),
    .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0]), .vga_hs(hs[0]), .vga_vs(vs[0]), .frame_start(fs[0]));

  vga_frame_reader #(.RD_LATENCY(1)) u_l1 (
    .pclk(pclk), .rst_n(rst_n), .frame_addr(fa[1]), .frame_data(fd[1]),
    .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1]), .vga_hs(hs[1]), .vga_vs(vs[1]), .frame_start(fs[1]));

  vga_frame_reader #(.RD_LATENCY(4)) u_l4 (
    .pclk(pclk), .rst_n(rst_n), .frame_addr(fa[2]), .frame_data(fd[2]),
    .vga_r(vr[2]), .vga_g(vg[2]), .vga_b(vb[2]), .vga_hs(hs[2]), .vga_vs(vs[2]), .frame_start(fs[2]));

  vga_frame_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LATENCY(3)
  ) u_small (
    .pclk(pclk), .rst_n(rst_n), .frame_addr(fa[3]), .frame_data(fd[3]),
    .vga_r(vr[3]), .vga_g(vg[3]), .vga_b(vb[3]), .vga_hs(hs[3]), .vga_vs(vs[3]), .frame_start(fs[3]));

  // RAM models: data = address[11:0] (or all-white), delayed by each instance's latency
  always @(posedge pclk) begin
    for (int i = 0; i < 4; i++) begin
      rp[i][0] <= white ? 12'hFFF : fa[i][11:0];
      for (int j = 1; j < 4; j++) rp[i][j] <= rp[i][j-1];
    end
  end
  assign fd[0] = rp[0][1];
  assign fd[1] = rp[1][0];
  assign fd[2] = rp[2][3];
  assign fd[3] = rp[3][2];

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  function automatic geo_t geo_of(input int i);
    geo_t g;
    if (i == 3) g = '{8, 2, 3, 2, 4, 1, 2, 1, 3};
    else        g = '{640, 16, 96, 48, 480, 10, 2, 33, (i == 0) ? 2 : (i == 1) ? 1 : 4};
    return g;
  endfunction

  function automatic string nm_of(input int i);
    case (i)
      0:       return "lat2";
      1:       return "lat1";
      2:       return "lat4";
      default: return "small";
    endcase
  endfunction

  // Expected outputs after n post-reset edges, from scan geometry alone
  function automatic void model(input int cyc, input geo_t g, input logic wh,
                                output logic [11:0] rgb, output logic hs_o, output logic vs_o,
                                output logic fs_o, output int addr);
    int ht, vt, ft, fb, r, fl, vis, p, q, h, v;
    ht = g.ha + g.hfp + g.hsw + g.hbp;
    vt = g.va + g.vfp + g.vsw + g.vbp;
    ft = ht * vt;
    fb = g.ha * g.va;
    r  = cyc % ft;
    fl = r / ht;
    if (fl < g.va) vis = fl * g.ha + (((r % ht) < g.ha) ? (r % ht) : g.ha);
    else           vis = fb;
    addr = vis % fb;
    p = cyc - g.lat - 1;
    if (p < 0) begin
      rgb = 12'h000; hs_o = 1'b1; vs_o = 1'b1; fs_o = 1'b0;
    end else begin
      q = p % ft;
      h = q % ht;
      v = q / ht;
      if (h < g.ha && v < g.va) rgb = wh ? 12'hFFF : 12'((v * g.ha + h) & 32'hFFF);
      else                      rgb = 12'h000;
      hs_o = !(h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hsw);
      vs_o = !(v >= g.va + g.vfp && v < g.va + g.vfp + g.vsw);
      fs_o = (q == 0);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got %0h expected %0h", nm, n, got, exp);
    end
  endtask

  always @(negedge pclk) begin
    for (int i = 0; i < 4; i++) begin
      model(n, geo_of(i), white, e_rgb, e_hs, e_vs, e_fs, e_addr);
      chk({nm_of(i), " rgb_hs_vs_fs"}, 32'({vr[i], vg[i], vb[i], hs[i], vs[i], fs[i]}),
          32'({e_rgb, e_hs, e_vs, e_fs}));
      chk({nm_of(i), " frame_addr"}, 32'(fa[i]), 32'(e_addr));
    end
    if (phase == 1) begin
      if (n == 3)    begin chk("lit fs@3", 32'(fs[0]), 32'd1); chk("lit rgb@3", 32'({vr[0], vg[0], vb[0]}), 32'h000); end
      if (n == 4)    begin chk("lit fs@4", 32'(fs[0]), 32'd0); chk("lit rgb@4", 32'({vr[0], vg[0], vb[0]}), 32'h001); end
      if (n == 642)  chk("lit rgb px639", 32'({vr[0], vg[0], vb[0]}), 32'h27F);
      if (n == 643)  chk("lit rgb blank", 32'({vr[0], vg[0], vb[0]}), 32'h000);
      if (n == 658)  chk("lit hs before", 32'(hs[0]), 32'd1);
      if (n == 659)  chk("lit hs fall", 32'(hs[0]), 32'd0);
      if (n == 754)  chk("lit hs last low", 32'(hs[0]), 32'd0);
      if (n == 755)  chk("lit hs rise", 32'(hs[0]), 32'd1);
      if (n == 1459) chk("lit hs fall line1", 32'(hs[0]), 32'd0);
      if (n == 800)  chk("lit addr line1", 32'(fa[0]), 32'd640);
      if (n == 2)    chk("lit lat1 fs", 32'(fs[1]), 32'd1);
      if (n == 3)    chk("lit lat1 rgb", 32'({vr[1], vg[1], vb[1]}), 32'h001);
      if (n == 4)    chk("lit lat4 fs early", 32'(fs[2]), 32'd0);
      if (n == 5)    chk("lit lat4 fs", 32'(fs[2]), 32'd1);
      if (n == 6)    chk("lit lat4 rgb", 32'({vr[2], vg[2], vb[2]}), 32'h001);
      if (n == 52)   chk("lit small addr last", 32'(fa[3]), 32'd31);
      if (n == 53)   chk("lit small addr wrap", 32'(fa[3]), 32'd0);
      if (n == 100)  chk("lit small addr hold", 32'(fa[3]), 32'd0);
      if (n == 78)   chk("lit small vs before", 32'(vs[3]), 32'd1);
      if (n == 79)   chk("lit small vs fall", 32'(vs[3]), 32'd0);
      if (n == 108)  chk("lit small vs last", 32'(vs[3]), 32'd0);
      if (n == 109)  chk("lit small vs rise", 32'(vs[3]), 32'd1);
      if (n == 4)    chk("lit small fs0", 32'(fs[3]), 32'd1);
      if (n == 124)  chk("lit small fs1", 32'(fs[3]), 32'd1);
    end
    if (phase == 2) begin
      if (n == 4)   chk("lit white px1", 32'({vr[0], vg[0], vb[0]}), 32'hFFF);
      if (n == 643) chk("lit white blank", 32'({vr[0], vg[0], vb[0]}), 32'h000);
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    phase  = 0;
    white  = 1'b0;
    rst_n  = 1'b0;
    repeat (6) @(negedge pclk);
    phase = 1;
    rst_n = 1'b1;
    repeat (2500) @(negedge pclk);
    // mid-frame reset, asserted between edges so only an asynchronous reset clears by the next sample
    @(posedge pclk);
    #5 rst_n = 1'b0;
    repeat (4) @(negedge pclk);
    phase = 2;
    white = 1'b1;
    rst_n = 1'b1;
    repeat (2500) @(negedge pclk);
    @(posedge pclk);
    #5 rst_n = 1'b0;
    repeat (3) @(negedge pclk);
    phase = 3;
    white = 1'b0;
    rst_n = 1'b1;
    repeat (1000) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
